// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key event classifier.
//   MS_W / ms_t        : width and type of the millisecond counters
//   ST_*               : 3-bit state encodings of the event FSM
//   key_state_t        : FSM state type built on those encodings
//   DEF_*              : default timing constants (50 MHz clock, 1 ms tick)
package key_pkg;

  localparam int MS_W = 16;
  typedef logic [MS_W-1:0] ms_t;
  localparam ms_t MS_MAX = '1;

  localparam int unsigned DEF_TICK_DIV  = 50000;
  localparam int unsigned DEF_LONG_MS   = 1000;
  localparam int unsigned DEF_DBL_MS    = 300;
  localparam int unsigned DEF_REPEAT_MS = 200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_LONG   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PRESS1 = ST_PRESS1,
    GAP    = ST_GAP,
    PRESS2 = ST_PRESS2,
    LONG   = ST_LONG
  } key_state_t;

endpackage

// File: rtl/key_tick_gen.sv
// key_tick_gen -- free-running prescaler producing a 1 ms tick.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   tick  : high for one cycle each time the counter wraps from TICK_DIV-1 to 0
module key_tick_gen
  import key_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_reg <= '0;
    else if (cnt_reg == LAST)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + CW'(1);
  end

  // Decoded straight from the counter register, so it is glitch-free and
  // exactly one cycle wide per period.
  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/key_event.sv
// key_event -- classifies a debounced key into single click, double click,
// long press and (optionally) auto-repeat events.
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   press        : debounced key level, 1 = pressed
//   short_pulse  : one-cycle pulse, confirmed single click
//   double_pulse : one-cycle pulse, confirmed double click
//   long_pulse   : one-cycle pulse when a hold reaches LONG_MS
//   repeat_pulse : one-cycle pulse every REPEAT_MS while a long hold continues
//   held         : level, high while a long press is in progress
// Build option: define KEY_REPEAT_EN to include the auto-repeat counter;
// otherwise repeat_pulse is constant 0.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned LONG_MS   = DEF_LONG_MS,
  parameter int unsigned DBL_MS    = DEF_DBL_MS,
  parameter int unsigned REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic press,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  if (TICK_DIV < 1 || LONG_MS < 1 || DBL_MS < 1 || REPEAT_MS < 1) begin : g_param_check
    $error("key_event: all timing parameters must be at least 1");
  end

  localparam ms_t LONG_LAST = ms_t'(LONG_MS - 1);
  localparam ms_t DBL_LAST  = ms_t'(DBL_MS - 1);

  key_state_t state_reg, state_next;
  ms_t        ms_cnt_reg;
  logic       press_q_reg;
  logic       armed_reg;
  logic       tick;
  logic       rise, fall;
  logic       short_next, double_next, long_next;
  logic       short_reg, double_reg, long_reg, held_reg;

  key_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // armed_reg stays low after reset until the key has been seen released,
  // so a key already held when reset drops never produces a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      press_q_reg <= press;
      if (!press)
        armed_reg <= 1'b1;
    end
  end

  assign rise = press & ~press_q_reg & armed_reg;
  assign fall = ~press & press_q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Edges are tested before timeouts so a release landing on the timeout
  // tick counts as a release.
  always_comb begin
    state_next  = state_reg;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise)
          state_next = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_next = GAP;
        end else if (tick && ms_cnt_reg == LONG_LAST) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_next = PRESS2;
        end else if (tick && ms_cnt_reg == DBL_LAST) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_next  = IDLE;
          double_next = 1'b1;
        end else if (tick && ms_cnt_reg == LONG_LAST) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      LONG: begin
        if (fall)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Any transition restarts the time base, including one that coincides
  // with a tick: that tick is absorbed rather than counted in the new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ms_cnt_reg <= '0;
    else if (state_next != state_reg)
      ms_cnt_reg <= '0;
    else if (tick && ms_cnt_reg != MS_MAX)
      ms_cnt_reg <= ms_cnt_reg + ms_t'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      short_reg  <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      held_reg   <= 1'b0;
    end else begin
      short_reg  <= short_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      held_reg   <= (state_next == LONG);
    end
  end

  assign short_pulse  = short_reg;
  assign double_pulse = double_reg;
  assign long_pulse   = long_reg;
  assign held         = held_reg;

`ifdef KEY_REPEAT_EN
  localparam ms_t REP_LAST = ms_t'(REPEAT_MS - 1);

  ms_t  rep_cnt_reg;
  logic repeat_reg;
  logic stay_long;

  // Only ticks spent wholly inside LONG count; the tick that entered LONG
  // and a tick coinciding with the release are both excluded.
  assign stay_long = (state_reg == LONG) && (state_next == LONG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_reg <= '0;
      repeat_reg  <= 1'b0;
    end else begin
      repeat_reg <= 1'b0;
      if (state_next == LONG && state_reg != LONG) begin
        rep_cnt_reg <= '0;
      end else if (stay_long && tick) begin
        if (rep_cnt_reg == REP_LAST) begin
          rep_cnt_reg <= '0;
          repeat_reg  <= 1'b1;
        end else begin
          rep_cnt_reg <= rep_cnt_reg + ms_t'(1);
        end
      end
    end
  end

  assign repeat_pulse = repeat_reg;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per 1 ms tick (50 MHz clk).
REQ-002 Parameter LONG_MS, default 1000, hold time in ms that classifies a long press.
REQ-003 Parameter DBL_MS, default 300, maximum release gap in ms before a second press still counts as a double click.
REQ-004 Parameter REPEAT_MS, default 200, auto-repeat period in ms while a long press is held.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 press  input  1  debounced key level from the key driver, 1 = pressed, synchronous to clk.
REQ-008 short_pulse  output  1  one-cycle pulse on a confirmed single click.
REQ-009 double_pulse  output  1  one-cycle pulse on a confirmed double click.
REQ-010 long_pulse  output  1  one-cycle pulse when a hold reaches LONG_MS.
REQ-011 repeat_pulse  output  1  one-cycle pulse every REPEAT_MS while a long hold continues; tied 0 when the repeat feature is compiled out.
REQ-012 held  output  1  level, 1 while the FSM is in LONG.

Function
REQ-013 The block SHALL register press into press_q; rise = press & ~press_q; fall = ~press & press_q.
REQ-014 The tick generator SHALL count free-running from 0 to TICK_DIV-1 and assert tick for one cycle on wrap.
REQ-015 ms_cnt SHALL be 16 bits, SHALL increment on tick, SHALL saturate at 0xFFFF, and SHALL clear on every state transition; an edge and a tick in the same cycle SHALL give a transition with ms_cnt cleared.
REQ-016 States SHALL be IDLE, PRESS1, GAP, PRESS2, and LONG.
REQ-017 IDLE: on rise, go to PRESS1.
REQ-018 PRESS1: on fall, go to GAP; on tick with ms_cnt == LONG_MS-1, go to LONG and pulse long_pulse.
REQ-019 GAP: on rise, go to PRESS2; on tick with ms_cnt == DBL_MS-1, go to IDLE and pulse short_pulse.
REQ-020 PRESS2: on fall, go to IDLE and pulse double_pulse; on reaching LONG_MS, go to LONG and pulse long_pulse, with no double_pulse.
REQ-021 LONG: on fall, go to IDLE with no pulse.
REQ-022 Fall SHALL take priority over a timeout tick in the same cycle.
REQ-023 All outputs SHALL be registered and asserted in the cycle after the deciding clock edge; at most one pulse output SHALL be high in any cycle.
REQ-024 Latency: short_pulse SHALL occur DBL_MS ms (±1 tick) after the first release; double_pulse SHALL occur 1 cycle after the second fall is detected.

Reset
REQ-025 While reset = 1: state = IDLE; press_q, the tick counter, ms_cnt, the repeat counter, and all outputs = 0.
REQ-026 Reset asserted mid-sequence SHALL discard the pending event; no pulse SHALL be emitted after reset is released, even if the key is then released.
REQ-027 If press = 1 when reset is released, the first rise SHALL NOT be detected until press has gone 0 and then 1.

Configuration
REQ-028 Macro KEY_REPEAT_EN defined: in LONG, the repeat counter SHALL count ticks and pulse repeat_pulse at each REPEAT_MS multiple after long_pulse; the counter SHALL clear on entering LONG.
REQ-029 KEY_REPEAT_EN undefined: the repeat counter SHALL be absent, repeat_pulse SHALL be constant 0, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package key_pkg SHALL hold the state encodings (3-bit localparams), the ms_cnt width, and the default timing constants.
REQ-031 The tick prescaler SHALL be a sub-module key_tick_gen (parameter TICK_DIV; ports clk, reset, tick).

Verification (sim params: TICK_DIV=10, LONG_MS=20, DBL_MS=5, REPEAT_MS=4)
REQ-032 Press 5 ms, release, idle 10 ms -> one short_pulse about 5 ms after release; no other pulses.
REQ-033 Press 3 ms, release 2 ms, press 3 ms, release -> one double_pulse 1 cycle after the second fall is seen; no short_pulse.
REQ-034 Hold 30 ms -> long_pulse at 20 ms; held = 1 from 20 ms until the fall; with KEY_REPEAT_EN, repeat_pulse at 24 ms and 28 ms; without it, none.
REQ-035 Press, release, second press held 25 ms -> long_pulse only, no double_pulse.
REQ-036 Press 10 ms, assert reset for 3 cycles, release key -> all outputs 0 throughout; state IDLE.
REQ-037 Fall coinciding with the LONG_MS-1 tick in PRESS1 -> GAP entered, no long_pulse; short_pulse follows DBL_MS later.
